count_ctrl: RTL and testbench

//   Session controller for the 4-digit BCD up/down counter (0000-9999 tenths).

---
 rtl/count_ctrl.sv | 138 +++++++++++++
 tb/tb_count_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/count_ctrl.sv
// count_ctrl: key debounce and SET/LOAD/RUN/PAUSE/ALARM session control for a BCD counter
module count_ctrl #(
    parameter int DEB_CYCLES   = 500000,
    parameter int FLASH_HALF   = 9000000,
    parameter int ALARM_CYCLES = 54000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        key_set_n,
    input  logic        key_go_n,
    input  logic        dir_sw,
    input  logic [15:0] cnt_value,
    input  logic [15:0] target,
    output logic        cnt_reset,
    output logic        cnt_load,
    output logic        cnt_ent,
    output logic        cnt_en_bu,
    output logic        cnt_updown,
    output logic        alarm_led,
    output logic [2:0]  state
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int FW = $clog2(FLASH_HALF + 1);
    localparam int AW = $clog2(ALARM_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
    localparam logic [DW-1:0] DEB_HOLD   = DW'(DEB_CYCLES);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_CYCLES - 1);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SET   = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_PAUSE = 3'd4;
    localparam logic [2:0] S_ALARM = 3'd5;

    logic [1:0]         r_s1, r_s2, r_press;
    logic [1:0][DW-1:0] r_deb;
    logic [2:0]         r_state, w_next;
    logic               r_match, r_reset, r_load, r_ent, r_en_bu, r_updown, r_led;
    logic               w_set, w_go, w_reset, w_load, w_ent, w_en_bu;
    logic [FW-1:0]      r_flash;
    logic [AW-1:0]      r_age;

    // Synchronise and debounce both keys (bit 0 = SET, bit 1 = GO); the counter parks one past the trigger so a held key fires once
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s1    <= 2'b11;
            r_s2    <= 2'b11;
            r_press <= 2'b00;
            r_deb   <= '0;
        end else begin
            r_s1 <= {key_go_n, key_set_n};
            r_s2 <= r_s1;
            for (int i = 0; i < 2; i++) begin
                r_press[i] <= !r_s2[i] && r_deb[i] == DEB_LAST;
                r_deb[i]   <= r_s2[i] ? '0 : (r_deb[i] == DEB_HOLD ? r_deb[i] : r_deb[i] + 1'b1);
            end
        end
    end

    assign w_set = r_press[0];
    assign w_go  = r_press[1] && !r_press[0];

    // Terminal-count compare, only meaningful while running so a stale value after LOAD never trips it
    always_ff @(posedge clk) begin
        if (!reset_n)
            r_match <= 1'b0;
        else
            r_match <= r_state == S_RUN && (r_updown ? cnt_value == 16'h0000 : cnt_value == target);
    end

    // State register with registered outputs so pulses line up with the state they belong to
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_reset  <= 1'b0;
            r_load   <= 1'b0;
            r_ent    <= 1'b0;
            r_en_bu  <= 1'b0;
            r_updown <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_reset  <= w_reset;
            r_load   <= w_load;
            r_ent    <= w_ent;
            r_en_bu  <= w_en_bu;
            r_updown <= w_next == S_LOAD ? dir_sw : r_updown;
        end
    end

    // Next-state decode; SET has priority over GO, and keys over the terminal match
    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:  w_next = w_set ? S_SET : w_go ? S_LOAD : S_IDLE;
            S_SET:   w_next = w_set ? S_IDLE : w_go ? S_LOAD : S_SET;
            S_LOAD:  w_next = S_RUN;
            S_RUN:   w_next = w_set ? S_IDLE : w_go ? S_PAUSE : r_match ? S_ALARM : S_RUN;
            S_PAUSE: w_next = w_set ? S_IDLE : w_go ? S_RUN : S_PAUSE;
            S_ALARM: w_next = (r_press != 2'b00 || r_age == ALARM_LAST) ? S_IDLE : S_ALARM;
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode from the state being entered; an up-count load clears the counter instead of loading it
    always_comb begin
        w_load  = w_next == S_LOAD && dir_sw;
        w_reset = (w_next == S_LOAD && !dir_sw) ||
                  ((r_state == S_RUN || r_state == S_PAUSE) && w_next == S_IDLE);
        w_ent   = w_next == S_RUN;
        w_en_bu = w_next == S_SET;
    end

    // Alarm flash and timeout timers, armed on entry and cleared whenever ALARM is not next
    always_ff @(posedge clk) begin
        if (!reset_n || w_next != S_ALARM) begin
            r_led   <= 1'b0;
            r_flash <= '0;
            r_age   <= '0;
        end else if (r_state != S_ALARM) begin
            r_led   <= 1'b1;
            r_flash <= '0;
            r_age   <= '0;
        end else begin
            r_age   <= r_age + 1'b1;
            r_flash <= r_flash == FLASH_LAST ? '0 : r_flash + 1'b1;
            r_led   <= r_flash == FLASH_LAST ? !r_led : r_led;
        end
    end

    assign cnt_reset  = r_reset;
    assign cnt_load   = r_load;
    assign cnt_ent    = r_ent;
    assign cnt_en_bu  = r_en_bu;
    assign cnt_updown = r_updown;
    assign alarm_led  = r_led;
    assign state      = r_state;
endmodule

// File: tb/tb_count_ctrl.sv
// tb_count_ctrl: directed and randomized checks of count_ctrl against a cycle-level behavioural model
module tb_count_ctrl;
    localparam int DEB = 4;
    localparam int FLASH = 3;
    localparam int ALRM = 20;
    localparam int IDLE = 0, SET = 1, LOAD = 2, RUN = 3, PAUSE = 4, ALARM = 5;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        key_set_n = 1'b0;
    logic        key_go_n = 1'b0;
    logic        dir_sw = 1'b1;
    logic [15:0] cnt_value = 16'h0500;
    logic [15:0] target = 16'h0012;
    logic        cnt_reset, cnt_load, cnt_ent, cnt_en_bu, cnt_updown, alarm_led;
    logic [2:0]  state;

    int n_vec = 0;
    int n_err = 0;
    int n_load = 0;
    int n_rst = 0;

    count_ctrl #(.DEB_CYCLES(DEB), .FLASH_HALF(FLASH), .ALARM_CYCLES(ALRM)) dut (
        .clk(clk), .reset_n(reset_n), .key_set_n(key_set_n), .key_go_n(key_go_n),
        .dir_sw(dir_sw), .cnt_value(cnt_value), .target(target),
        .cnt_reset(cnt_reset), .cnt_load(cnt_load), .cnt_ent(cnt_ent),
        .cnt_en_bu(cnt_en_bu), .cnt_updown(cnt_updown), .alarm_led(alarm_led), .state(state)
    );

    always #5 clk = ~clk;

    // Behavioural model: a press is the DEB-th consecutive low sample of the key seen through two flops;
    // the flash phase is derived from the number of cycles spent in ALARM.
    logic [1:0] m_d1, m_d2, m_press, m_new;
    int         m_run [2];
    int         m_state, m_age;
    logic       m_hit, m_ud;
    logic [8:0] m_exp;

    always @(posedge clk) begin
        int cur, nxt;
        logic s, g;
        if (!reset_n) begin
            m_d1 = 2'b11; m_d2 = 2'b11; m_press = 2'b00;
            m_run[0] = 0; m_run[1] = 0;
            m_state = IDLE; m_age = 0; m_hit = 1'b0; m_ud = 1'b0; m_exp = '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_run[i] = m_d2[i] ? 0 : m_run[i] + 1;
                m_new[i] = m_run[i] == DEB;
            end
            m_d2 = m_d1;
            m_d1 = {key_go_n, key_set_n};
            s = m_press[0];
            g = m_press[1] && !m_press[0];
            cur = m_state;
            nxt = cur;
            if (cur == IDLE) nxt = s ? SET : g ? LOAD : IDLE;
            else if (cur == SET) nxt = s ? IDLE : g ? LOAD : SET;
            else if (cur == LOAD) nxt = RUN;
            else if (cur == RUN) nxt = s ? IDLE : g ? PAUSE : m_hit ? ALARM : RUN;
            else if (cur == PAUSE) nxt = s ? IDLE : g ? RUN : PAUSE;
            else if (cur == ALARM) nxt = (s || m_press[1] || m_age == ALRM - 1) ? IDLE : ALARM;
            else nxt = IDLE;
            m_hit = cur == RUN && (m_ud ? cnt_value == 16'h0000 : cnt_value == target);
            m_age = cur == ALARM ? m_age + 1 : 0;
            if (nxt == LOAD) m_ud = dir_sw;
            m_exp = {3'(nxt),
                     (nxt == LOAD && !dir_sw) || ((cur == RUN || cur == PAUSE) && nxt == IDLE),
                     nxt == LOAD && dir_sw,
                     nxt == RUN,
                     nxt == SET,
                     m_ud,
                     nxt == ALARM && (m_age / FLASH) % 2 == 0};
            m_press = m_new;
            m_state = nxt;
        end
    end

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            n_load += int'(cnt_load);
            n_rst  += int'(cnt_reset);
            expect_eq("vec", 32'({state, cnt_reset, cnt_load, cnt_ent, cnt_en_bu, cnt_updown, alarm_led}), 32'(m_exp));
        end
    endtask

    task automatic press(input logic s, input logic g);
        key_set_n = ~s;
        key_go_n  = ~g;
        step(DEB + 1);
        key_set_n = 1'b1;
        key_go_n  = 1'b1;
        step(4);
    endtask

    initial begin
        int l0, r0;
        logic [19:0] led_bits;
        logic [15:0] seq [11];
        seq = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006,
                16'h0007, 16'h0008, 16'h0009, 16'h0010, 16'h0011};

        // 1. reset with keys held low
        step(3);
        expect_eq("reset_outputs", 32'({state, cnt_reset, cnt_load, cnt_ent, cnt_en_bu, cnt_updown, alarm_led}), 0);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            expect_eq("post_reset_idle", 32'(state), IDLE);
        end
        key_set_n = 1'b1;
        key_go_n  = 1'b1;
        step(4);
        expect_eq("both_keys_set_wins", 32'(state), SET);
        press(1'b1, 1'b0);
        expect_eq("set_to_idle", 32'(state), IDLE);

        // 2. debounce
        key_go_n = 1'b0;
        step(3);
        key_go_n = 1'b1;
        step(6);
        expect_eq("short_glitch", 32'(state), IDLE);
        l0 = n_load;
        key_go_n = 1'b0;
        step(10);
        key_go_n = 1'b1;
        step(4);
        expect_eq("long_press_loads", 32'(n_load - l0), 1);
        expect_eq("long_press_run", 32'(state), RUN);
        press(1'b1, 1'b0);
        expect_eq("run_abort_idle", 32'(state), IDLE);

        // 3. set then down load
        press(1'b1, 1'b0);
        expect_eq("set_en_bu", 32'(cnt_en_bu), 1);
        dir_sw = 1'b1;
        l0 = n_load;
        press(1'b0, 1'b1);
        expect_eq("down_load_pulse", 32'(n_load - l0), 1);
        expect_eq("down_updown", 32'(cnt_updown), 1);
        expect_eq("down_ent", 32'(cnt_ent), 1);
        cnt_value = 16'h0000;
        step(1);
        expect_eq("down_match_lag", 32'(state), RUN);
        step(1);
        expect_eq("down_alarm", 32'(state), ALARM);
        expect_eq("alarm_ent_off", 32'(cnt_ent), 0);
        press(1'b1, 1'b0);
        expect_eq("alarm_key_exit", 32'({state, alarm_led}), 0);

        // 4. up run to 0012 and alarm timeout
        dir_sw = 1'b0;
        target = 16'h0012;
        r0 = n_rst;
        l0 = n_load;
        press(1'b0, 1'b1);
        expect_eq("up_reset_pulse", 32'(n_rst - r0), 1);
        expect_eq("up_no_load", 32'(n_load - l0), 0);
        expect_eq("up_run", 32'({state, cnt_updown}), {RUN, 1'b0});
        foreach (seq[i]) begin
            cnt_value = seq[i];
            step(3);
        end
        expect_eq("up_still_run", 32'(state), RUN);
        cnt_value = 16'h0012;
        step(2);
        expect_eq("up_alarm", 32'(state), ALARM);
        for (int i = 0; i < 20; i++) begin
            led_bits[19-i] = alarm_led;
            step(1);
        end
        expect_eq("led_pattern", 32'(led_bits), 32'(20'b11100011100011100011));
        expect_eq("alarm_timeout", 32'({state, alarm_led}), 0);

        // 5. pause / resume / abort
        dir_sw = 1'b1;
        cnt_value = 16'h0300;
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        expect_eq("pause", 32'({state, cnt_ent}), {PAUSE, 1'b0});
        press(1'b0, 1'b1);
        expect_eq("resume", 32'({state, cnt_ent}), {RUN, 1'b1});
        r0 = n_rst;
        press(1'b1, 1'b0);
        expect_eq("abort_reset", 32'(n_rst - r0), 1);
        expect_eq("abort_idle", 32'(state), IDLE);
        press(1'b0, 1'b1);
        r0 = n_rst;
        press(1'b1, 1'b1);
        expect_eq("both_in_run", 32'(state), IDLE);
        expect_eq("both_in_run_reset", 32'(n_rst - r0), 1);

        // 6. reset mid-ALARM and mid-LOAD
        press(1'b0, 1'b1);
        cnt_value = 16'h0000;
        step(2);
        expect_eq("alarm_before_reset", 32'({state, alarm_led}), {ALARM, 1'b1});
        reset_n = 1'b0;
        step(1);
        expect_eq("alarm_reset", 32'({state, alarm_led}), 0);
        reset_n = 1'b1;
        step(1);
        dir_sw = 1'b0;
        cnt_value = 16'h0300;
        key_go_n = 1'b0;
        for (int i = 0; i < 15 && state != 3'(LOAD); i++) step(1);
        expect_eq("reach_load", 32'(state), LOAD);
        reset_n = 1'b0;
        key_go_n = 1'b1;
        r0 = n_rst;
        l0 = n_load;
        step(1);
        expect_eq("load_reset", 32'({state, cnt_reset, cnt_load}), 0);
        reset_n = 1'b1;
        step(6);
        expect_eq("no_pulse_after_reset", 32'((n_rst - r0) + (n_load - l0)), 0);
        expect_eq("load_reset_idle", 32'(state), IDLE);

        // randomized phase against the model
        for (int r = 0; r < 60; r++) begin
            key_set_n = $urandom_range(0, 3) != 0;
            key_go_n  = $urandom_range(0, 2) != 0;
            dir_sw    = 1'($urandom);
            target    = $urandom_range(0, 1) ? 16'h0000 : 16'h0042;
            case ($urandom_range(0, 2))
                0: cnt_value = 16'h0000;
                1: cnt_value = target;
                default: cnt_value = 16'($urandom);
            endcase
            reset_n = $urandom_range(0, 19) != 0;
            step($urandom_range(1, 8));
        end
        reset_n = 1'b1;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
